// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory with a wait timeout.
// Optional addi support is enabled by defining CONTROLE_ADDI_EN.
module controle_multiciclo #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       Op_code,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             ReadMem,
  output logic             WriteMem,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             WriteReg,
  output logic             OrigALUA,
  output logic [1:0]       OrigALUB,
  output logic [1:0]       Op_ALU,
  output logic [1:0]       PCSource,
  output logic [3:0]       estado,
  output logic             erro,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEMADDR   = 4'd3,
    MEMREAD   = 4'd4,
    MEMWB     = 4'd5,
    MEMWRITE  = 4'd6,
    EXEC_R    = 4'd7,
    RTYPE_WB  = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
`ifdef CONTROLE_ADDI_EN
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12,
`endif
    TRAP      = 4'd15
  } state_t;

  localparam bit             TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;

  // Memory handshake: in FETCH/MEMREAD/MEMWRITE the request is held until mem_ready=1,
  // which completes the access in that same cycle; mem_ready is ignored in all other states.
  assign in_wait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout_hit = TMO_EN && in_wait && !mem_ready && (wait_cnt == TMO_LAST);
  assign estado      = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + 1'b1;

      if (in_wait && !mem_ready && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                        wait_cnt <= '0;

      case (state)
        IDLE:     state <= FETCH;
        FETCH: begin
          if (mem_ready)        state <= DECODE;
          else if (timeout_hit) state <= TRAP;
        end
        DECODE: begin
          case (Op_code)
            6'h00:        state <= EXEC_R;
            6'h23, 6'h2B: state <= MEMADDR;
            6'h04:        state <= BRANCH;
            6'h02:        state <= JUMP;
`ifdef CONTROLE_ADDI_EN
            6'h08:        state <= ADDI_EXEC;
`endif
            default:      state <= TRAP;
          endcase
        end
        MEMADDR: begin
          if (Op_code == 6'h23)      state <= MEMREAD;
          else if (Op_code == 6'h2B) state <= MEMWRITE;
          else                       state <= TRAP;
        end
        MEMREAD: begin
          if (mem_ready)        state <= MEMWB;
          else if (timeout_hit) state <= TRAP;
        end
        MEMWRITE: begin
          if (mem_ready)        state <= FETCH;
          else if (timeout_hit) state <= TRAP;
        end
        MEMWB:     state <= FETCH;
        EXEC_R:    state <= RTYPE_WB;
        RTYPE_WB:  state <= FETCH;
        BRANCH:    state <= FETCH;
        JUMP:      state <= FETCH;
`ifdef CONTROLE_ADDI_EN
        ADDI_EXEC: state <= ADDI_WB;
        ADDI_WB:   state <= FETCH;
`endif
        TRAP:      state <= TRAP;
        default:   state <= TRAP;
      endcase
    end
  end

  // Control outputs are decoded from the state; only FETCH/MEMWRITE look at mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    WriteReg    = 1'b0;
    OrigALUA    = 1'b0;
    OrigALUB    = 2'b00;
    Op_ALU      = 2'b00;
    PCSource    = 2'b00;
    erro        = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        ReadMem  = 1'b1;
        OrigALUB = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      DECODE:   OrigALUB = 2'b11;
      MEMADDR: begin
        OrigALUA = 1'b1;
        OrigALUB = 2'b10;
      end
      MEMREAD: begin
        ReadMem = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        WriteReg = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEMWRITE: begin
        WriteMem = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      EXEC_R: begin
        OrigALUA = 1'b1;
        Op_ALU   = 2'b10;
      end
      RTYPE_WB: begin
        RegDst   = 1'b1;
        WriteReg = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        OrigALUA    = 1'b1;
        Op_ALU      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
`ifdef CONTROLE_ADDI_EN
      ADDI_EXEC: begin
        OrigALUA = 1'b1;
        OrigALUB = 2'b10;
      end
      ADDI_WB: begin
        WriteReg = 1'b1;
        retire   = 1'b1;
      end
`endif
      TRAP:    erro = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed testbench for controle_multiciclo (CNT_W=4 so the retire counter wrap is reachable).
module tb_controle_multiciclo;

  logic       clock;
  logic       reset_n;
  logic [5:0] Op_code;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, ReadMem, WriteMem, IRWrite;
  logic       MemtoReg, RegDst, WriteReg, OrigALUA;
  logic [1:0] OrigALUB, Op_ALU, PCSource;
  logic [3:0] estado;
  logic       erro, retire;
  logic [3:0] instr_count;
  logic [15:0] ctrl;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_count = '0;

  controle_multiciclo #(.MEM_TIMEOUT(16), .TMO_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .Op_code(Op_code), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .WriteReg(WriteReg), .OrigALUA(OrigALUA), .OrigALUB(OrigALUB), .Op_ALU(Op_ALU),
    .PCSource(PCSource), .estado(estado), .erro(erro), .retire(retire),
    .instr_count(instr_count)
  );

  // {PCWrite,PCWriteCond,IorD,ReadMem,WriteMem,IRWrite,MemtoReg,RegDst,WriteReg,OrigALUA,OrigALUB,Op_ALU,PCSource}
  assign ctrl = {PCWrite, PCWriteCond, IorD, ReadMem, WriteMem, IRWrite, MemtoReg, RegDst,
                 WriteReg, OrigALUA, OrigALUB, Op_ALU, PCSource};

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive mem_ready for one cycle, check the current state's outputs, then advance one clock.
  task automatic run_cycle(input string tag, input logic rdy, input logic [3:0] st,
                           input logic [15:0] ctl, input logic ret);
    mem_ready = rdy;
    #1;
    check({tag, "/estado"}, 32'(estado), 32'(st));
    check({tag, "/ctrl"}, 32'(ctl), 32'(ctrl));
    check({tag, "/retire"}, 32'(retire), 32'(ret));
    check({tag, "/erro"}, 32'(erro), 32'(st == 4'd15));
    if (ret) exp_count = exp_count + 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic check_count(input string tag);
    check({tag, "/count"}, 32'(instr_count), 32'(exp_count));
  endtask

  task automatic do_fetch(input string tag);
    run_cycle({tag, "_fetch"}, 1'b1, 4'd1, 16'h9410, 1'b0);
  endtask

  task automatic do_r();
    Op_code = 6'h00;
    do_fetch("r");
    run_cycle("r_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("r_exec", 1'b1, 4'd7, 16'h0048, 1'b0);
    run_cycle("r_wb", 1'b1, 4'd8, 16'h0180, 1'b1);
    check_count("r");
  endtask

  task automatic do_beq();
    Op_code = 6'h04;
    do_fetch("beq");
    run_cycle("beq_dec", 1'b0, 4'd2, 16'h0030, 1'b0);
    run_cycle("beq_br", 1'b0, 4'd9, 16'h4045, 1'b1);
    check_count("beq");
  endtask

  task automatic do_j();
    Op_code = 6'h02;
    do_fetch("j");
    run_cycle("j_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("j_jmp", 1'b1, 4'd10, 16'h8002, 1'b1);
    check_count("j");
  endtask

  task automatic check_trap(input string tag);
    mem_ready = 1'b1;
    #1;
    check({tag, "/estado"}, 32'(estado), 32'd15);
    check({tag, "/erro"}, 32'(erro), 32'd1);
    check({tag, "/ctrl"}, 32'(ctrl), 32'd0);
    check({tag, "/retire"}, 32'(retire), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "/rst_estado"}, 32'(estado), 32'd0);
    check({tag, "/rst_count"}, 32'(instr_count), 32'd0);
    check({tag, "/rst_ctrl"}, 32'(ctrl), 32'd0);
    check({tag, "/rst_erro"}, 32'(erro), 32'd0);
    exp_count = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_cycle({tag, "_idle"}, 1'b1, 4'd0, 16'h0000, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    Op_code   = 6'h00;
    #1;
    check("por/estado", 32'(estado), 32'd0);
    check("por/count", 32'(instr_count), 32'd0);
    check("por/ctrl", 32'(ctrl), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_cycle("idle", 1'b0, 4'd0, 16'h0000, 1'b0);

    // lw with no waits: 1,2,3,4,5 then back to FETCH
    Op_code = 6'h23;
    do_fetch("lw");
    run_cycle("lw_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("lw_addr", 1'b1, 4'd3, 16'h0060, 1'b0);
    run_cycle("lw_rd", 1'b1, 4'd4, 16'h3000, 1'b0);
    run_cycle("lw_wb", 1'b1, 4'd5, 16'h0280, 1'b1);
    check("lw/count1", 32'(instr_count), 32'd1);

    // sw with three wait cycles in MEMWRITE
    Op_code = 6'h2B;
    do_fetch("sw");
    run_cycle("sw_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("sw_addr", 1'b1, 4'd3, 16'h0060, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle("sw_wait", 1'b0, 4'd6, 16'h2800, 1'b0);
    run_cycle("sw_done", 1'b1, 4'd6, 16'h2800, 1'b1);
    check("sw/count2", 32'(instr_count), 32'd2);

    // R/beq/j mix up to 15 retirements, then wrap to 0
    do_r();
    do_beq();
    do_j();
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       do_r();
        1:       do_beq();
        default: do_j();
      endcase
    end
    check("wrap/count15", 32'(instr_count), 32'd15);
    do_j();
    check("wrap/count0", 32'(instr_count), 32'd0);

    // mem_ready arriving on the last allowed wait cycle beats the timeout
    Op_code = 6'h04;
    for (int i = 0; i < 15; i++) run_cycle("late_wait", 1'b0, 4'd1, 16'h1010, 1'b0);
    run_cycle("late_fetch", 1'b1, 4'd1, 16'h9410, 1'b0);
    run_cycle("late_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("late_br", 1'b1, 4'd9, 16'h4045, 1'b1);
    check("late/count1", 32'(instr_count), 32'd1);

    // reset in the middle of a stalled MEMREAD
    Op_code = 6'h23;
    do_fetch("lw2");
    run_cycle("lw2_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    run_cycle("lw2_addr", 1'b1, 4'd3, 16'h0060, 1'b0);
    run_cycle("lw2_wait", 1'b0, 4'd4, 16'h3000, 1'b0);
    run_cycle("lw2_wait", 1'b0, 4'd4, 16'h3000, 1'b0);
    do_reset("midrd");
    run_cycle("midrd_fetch", 1'b0, 4'd1, 16'h1010, 1'b0);

    // fetch timeout: 16 cycles without mem_ready
    for (int i = 0; i < 15; i++) run_cycle("tmo_wait", 1'b0, 4'd1, 16'h1010, 1'b0);
    for (int i = 0; i < 3; i++) check_trap("tmo_trap");
    check("tmo/count", 32'(instr_count), 32'd0);
    do_reset("tmo");

    // illegal opcode
    Op_code = 6'h3F;
    do_fetch("ill");
    run_cycle("ill_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
    check_trap("ill_trap");
    check_trap("ill_trap");
    do_reset("ill");

    // addi: legal only when the feature is built in
    Op_code = 6'h08;
    do_fetch("addi");
    run_cycle("addi_dec", 1'b1, 4'd2, 16'h0030, 1'b0);
`ifdef CONTROLE_ADDI_EN
    run_cycle("addi_exec", 1'b1, 4'd11, 16'h0060, 1'b0);
    run_cycle("addi_wb", 1'b1, 4'd12, 16'h0080, 1'b1);
    run_cycle("addi_next", 1'b0, 4'd1, 16'h1010, 1'b0);
    check("addi/count1", 32'(instr_count), 32'd1);
`else
    check_trap("addi_trap");
    check("addi/count0", 32'(instr_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
